fill_drain_sequencer: RTL and testbench

- Downstream/controlling stage for water_flow_monitor: sequences one wash-tub cycle FILL -> HOLD -> DRAIN.
- Drives the monitor's mode and reset, and the fill/drain valves.
- Consumes the monitor's error_flag to retry, then declares a fault.
- Sits between the top-level wash program FSM and the valve drivers.

---
 rtl/fill_drain_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fill_drain_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_drain_sequencer.sv
// -----------------------------------------------------------------------------
// fill_drain_sequencer
//   Runs one wash-tub cycle FILL -> HOLD -> DRAIN -> DONE. It drives the
//   water_flow_monitor (mode, monitor_reset) and the two valves. Monitor
//   error_flag events are retried a bounded number of times per phase, and
//   after that the block declares a sticky fault.
//
//   Optional feature macro: FILL_DRAIN_OVERFLOW_GUARD_EN
//     When defined, a level at or above MAX_LEVEL forces FAULT with code 3.
//     While in that fault, the drain valve stays open until the level is at
//     or below DRAIN_TARGET.
//
// Ports
//   clk                 in   system clock
//   reset               in   asynchronous active-high reset
//   start               in   begin a cycle (sampled only in IDLE)
//   abort               in   return to IDLE (ignored in FAULT)
//   fault_clear         in   leave FAULT to IDLE
//   water_level_sensor  in   current tub level, unsigned 10-bit
//   error_flag          in   stall indication from water_flow_monitor
//   mode                out  to monitor: 1 = filling, 0 = draining
//   monitor_reset       out  to monitor reset input
//   fill_valve          out  open inlet valve
//   drain_valve         out  open drain valve
//   busy                out  high in FILL, HOLD, DRAIN
//   done                out  one-cycle pulse on cycle completion
//   fault               out  high while in FAULT
//   fault_code          out  0 none, 1 fill stall, 2 drain stall, 3 overflow
// -----------------------------------------------------------------------------
module fill_drain_sequencer #(
    parameter logic [9:0]  FILL_TARGET  = 10'd300,
    parameter logic [9:0]  DRAIN_TARGET = 10'd20,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned MAX_RETRY    = 2
`ifdef FILL_DRAIN_OVERFLOW_GUARD_EN
    ,
    parameter logic [9:0]  MAX_LEVEL    = 10'd900
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       fault_clear,
    input  logic [9:0] water_level_sensor,
    input  logic       error_flag,
    output logic       mode,
    output logic       monitor_reset,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned RETRY_W = 3;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]          fault_code_d;
    logic                retry_pulse;
    logic                phase_entry;
    logic                mode_d, monitor_reset_d, fill_valve_d, drain_valve_d;
    logic                busy_d, done_d, fault_d;

    // Next-state and counter logic
    always_comb begin
        state_d      = state_q;
        retry_cnt_d  = retry_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        fault_code_d = fault_code;
        retry_pulse  = 1'b0;

        if (abort && (state_q != ST_FAULT)) begin
            state_d = ST_IDLE;
        end
`ifdef FILL_DRAIN_OVERFLOW_GUARD_EN
        else if ((state_q != ST_FAULT) && (water_level_sensor >= MAX_LEVEL)) begin
            state_d      = ST_FAULT;
            fault_code_d = 2'd3;
        end
`endif
        else begin
            unique case (state_q)
                ST_IDLE: begin
                    retry_cnt_d = '0;
                    if (start) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Target level wins over a same-cycle error event.
                    if (water_level_sensor >= FILL_TARGET) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else if (error_flag && !monitor_reset) begin
                        if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                            retry_pulse = 1'b1;
                        end else begin
                            state_d      = ST_FAULT;
                            fault_code_d = 2'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_d     = ST_DRAIN;
                        retry_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (water_level_sensor <= DRAIN_TARGET) begin
                        state_d = ST_DONE;
                    end else if (error_flag && !monitor_reset) begin
                        if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                            retry_pulse = 1'b1;
                        end else begin
                            state_d      = ST_FAULT;
                            fault_code_d = 2'd2;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clear) begin
                        state_d      = ST_IDLE;
                        fault_code_d = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output values for the cycle after the edge, derived from the next state
    always_comb begin
        phase_entry   = (state_d != state_q) &&
                        ((state_d == ST_FILL) || (state_d == ST_DRAIN));
        mode_d        = (state_d != ST_DRAIN);
        fill_valve_d  = (state_d == ST_FILL);
        drain_valve_d = (state_d == ST_DRAIN);
`ifdef FILL_DRAIN_OVERFLOW_GUARD_EN
        // Overflow fault keeps emptying the tub down to the drain target.
        if ((state_d == ST_FAULT) && (fault_code_d == 2'd3) &&
            (water_level_sensor > DRAIN_TARGET)) begin
            drain_valve_d = 1'b1;
        end
`endif
        busy_d  = (state_d == ST_FILL) || (state_d == ST_HOLD) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
        // Monitor is held in reset outside the active phases, and pulsed on
        // phase entry and after each retry.
        monitor_reset_d = !((state_d == ST_FILL) || (state_d == ST_DRAIN)) ||
                          phase_entry || retry_pulse;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            retry_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            mode          <= 1'b1;
            monitor_reset <= 1'b1;
            fill_valve    <= 1'b0;
            drain_valve   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= 2'd0;
        end else begin
            state_q       <= state_d;
            retry_cnt_q   <= retry_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            mode          <= mode_d;
            monitor_reset <= monitor_reset_d;
            fill_valve    <= fill_valve_d;
            drain_valve   <= drain_valve_d;
            busy          <= busy_d;
            done          <= done_d;
            fault         <= fault_d;
            fault_code    <= fault_code_d;
        end
    end

endmodule

// File: tb/tb_fill_drain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fill_drain_sequencer
//   Directed bench for fill_drain_sequencer with hand-computed expectations.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_fill_drain_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       fault_clear;
    logic [9:0] water_level_sensor;
    logic       error_flag;
    logic       mode;
    logic       monitor_reset;
    logic       fill_valve;
    logic       drain_valve;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    fill_drain_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .fault_clear        (fault_clear),
        .water_level_sensor (water_level_sensor),
        .error_flag         (error_flag),
        .mode               (mode),
        .monitor_reset      (monitor_reset),
        .fill_valve         (fill_valve),
        .drain_valve        (drain_valve),
        .busy               (busy),
        .done               (done),
        .fault              (fault),
        .fault_code         (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; valves must never be open together.
    task automatic tick();
        @(posedge clk);
        #1;
        check("valves_exclusive", 32'(fill_valve & drain_valve), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full nominal cycle: fill 50 -> 310 in +20 steps, hold, drain 310 -> 10.
    task automatic normal_cycle();
        int dones;
        dones = 0;
        water_level_sensor = 10'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fill_entry_valve", 32'(fill_valve), 32'd1);
        check("fill_entry_mreset", 32'(monitor_reset), 32'd1);
        check("fill_entry_busy", 32'(busy), 32'd1);
        check("fill_entry_mode", 32'(mode), 32'd1);
        for (int k = 0; k < 13; k++) begin
            water_level_sensor = 10'(70 + 20 * k);
            tick();
            check("fill_valve", 32'(fill_valve), 32'((70 + 20 * k) < 300));
            check("fill_mreset", 32'(monitor_reset), 32'((70 + 20 * k) >= 300));
        end
        check("hold_entry_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("hold_valves", 32'(fill_valve | drain_valve), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        tick();
        check("drain_entry_valve", 32'(drain_valve), 32'd1);
        check("drain_entry_mode", 32'(mode), 32'd0);
        check("drain_entry_mreset", 32'(monitor_reset), 32'd1);
        for (int j = 0; j < 15; j++) begin
            water_level_sensor = 10'(290 - 20 * j);
            tick();
            dones += int'(done);
            check("drain_valve", 32'(drain_valve), 32'((290 - 20 * j) > 20));
            check("drain_done", 32'(done), 32'((290 - 20 * j) <= 20));
        end
        check("done_busy", 32'(busy), 32'd0);
        tick();
        dones += int'(done);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_mreset", 32'(monitor_reset), 32'd1);
        check("done_pulse_count", 32'(dones), 32'd1);
        check("normal_no_fault", 32'(fault), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; fault_clear = 1'b0;
        water_level_sensor = 10'd0; error_flag = 1'b0;

        // Reset state
        ticks(2);
        check("rst_mode", 32'(mode), 32'd1);
        check("rst_mreset", 32'(monitor_reset), 32'd1);
        check("rst_valves", 32'({fill_valve, drain_valve}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Nominal cycle
        normal_cycle();

        // Fill stall: entry-cycle error ignored, two retries, third faults
        water_level_sensor = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        check("entry_err_ignored", 32'(monitor_reset), 32'd0);
        check("entry_err_fill", 32'(fill_valve), 32'd1);
        tick();
        for (int e = 0; e < 2; e++) begin
            error_flag = 1'b1;
            tick();
            error_flag = 1'b0;
            check("fill_retry_pulse", 32'(monitor_reset), 32'd1);
            check("fill_retry_fill", 32'(fill_valve), 32'd1);
            tick();
            check("fill_retry_end", 32'(monitor_reset), 32'd0);
            ticks(2);
        end
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        check("fill_fault", 32'(fault), 32'd1);
        check("fill_fault_code", 32'(fault_code), 32'd1);
        check("fill_fault_valves", 32'({fill_valve, drain_valve}), 32'd0);
        check("fill_fault_busy", 32'(busy), 32'd0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_code_sticky", 32'(fault_code), 32'd1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clear_fault", 32'(fault), 32'd0);
        check("clear_code", 32'(fault_code), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);

        // Two fill retries, then target reached with a same-cycle error
        water_level_sensor = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int e = 0; e < 2; e++) begin
            error_flag = 1'b1;
            tick();
            error_flag = 1'b0;
            ticks(2);
        end
        water_level_sensor = 10'd300;
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        check("lvl_wins_fill", 32'(fill_valve), 32'd0);
        check("lvl_wins_busy", 32'(busy), 32'd1);
        check("lvl_wins_fault", 32'(fault), 32'd0);
        water_level_sensor = 10'd200;
        ticks(15);
        check("hold_16_still", 32'(drain_valve), 32'd0);
        tick();
        check("drain_entry2", 32'(drain_valve), 32'd1);

        // Drain stall: retry count restarts for the drain phase
        tick();
        for (int e = 0; e < 2; e++) begin
            error_flag = 1'b1;
            tick();
            error_flag = 1'b0;
            check("drain_retry_pulse", 32'(monitor_reset), 32'd1);
            check("drain_retry_fault", 32'(fault), 32'd0);
            ticks(3);
        end
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        check("drain_fault", 32'(fault), 32'd1);
        check("drain_fault_code", 32'(fault_code), 32'd2);
        check("drain_fault_valve", 32'(drain_valve), 32'd0);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clear2_code", 32'(fault_code), 32'd0);

        // Abort mid-fill at level 150
        water_level_sensor = 10'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            water_level_sensor = 10'(70 + 20 * k);
            tick();
        end
        check("pre_abort_fill", 32'(fill_valve), 32'd1);
        check("pre_abort_level", 32'(water_level_sensor), 32'd150);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_fill", 32'(fill_valve), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_idle_done", 32'(done), 32'd0);
        normal_cycle();

        // Asynchronous reset during DRAIN
        water_level_sensor = 10'd310;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        water_level_sensor = 10'd200;
        ticks(16);
        check("pre_rst_drain", 32'(drain_valve), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_drain", 32'(drain_valve), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_mreset", 32'(monitor_reset), 32'd1);

`ifdef FILL_DRAIN_OVERFLOW_GUARD_EN
        // Overflow during fill drains to the target then closes
        water_level_sensor = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        water_level_sensor = 10'd900;
        tick();
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_code", 32'(fault_code), 32'd3);
        check("ovf_drain", 32'(drain_valve), 32'd1);
        check("ovf_fill", 32'(fill_valve), 32'd0);
        water_level_sensor = 10'd21;
        tick();
        check("ovf_drain_21", 32'(drain_valve), 32'd1);
        water_level_sensor = 10'd20;
        tick();
        check("ovf_drain_20", 32'(drain_valve), 32'd0);
        check("ovf_code_held", 32'(fault_code), 32'd3);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("ovf_clear", 32'(fault_code), 32'd0);
`else
        // Without the guard, a very high level in FILL is just target reached
        water_level_sensor = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        water_level_sensor = 10'd900;
        tick();
        check("no_ovf_fault", 32'(fault), 32'd0);
        check("no_ovf_code", 32'(fault_code), 32'd0);
        check("no_ovf_hold", 32'(busy & ~fill_valve), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
